// File: rtl/req_arbiter_pkg.sv
// Shared types and defaults for the request arbiter.
package req_arbiter_pkg;

   typedef enum logic {
      ArbIdle = 1'b0,
      ArbBusy = 1'b1
   } arb_state_e;

   localparam int unsigned DefN       = 4;
   localparam int unsigned DefIdxW    = 2;
   localparam int unsigned DefMaxHold = 15;
   localparam int unsigned DefHoldW   = 4;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/req_arbiter_pick.sv
// Winner selection: rotate requests by last owner, take highest set bit, rotate back.
module req_arbiter_pick #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last,
   input  logic             fixed_pri,
   output logic [IDX_W-1:0] winner,
   output logic             any_req
);

   logic [IDX_W-1:0] base;
   logic [2*N-1:0]   dbl;
   logic [N-1:0]     rot;
   logic [IDX_W-1:0] hi;
   logic [IDX_W:0]   sum;

   always_comb begin
      base = fixed_pri ? '0 : last;
      // Bit i of rot is requester (i + base) mod N, so base-1 lands on the top bit.
      dbl  = {req, req} >> base;
      rot  = dbl[N-1:0];
      hi   = '0;
      for (int i = 0; i < N; i++) begin
         if (rot[i]) hi = IDX_W'(i);
      end
      sum = {1'b0, hi} + {1'b0, base};
      if (sum >= (IDX_W + 1)'(N)) sum = sum - (IDX_W + 1)'(N);
      winner  = sum[IDX_W-1:0];
      any_req = |req;
   end

endmodule

// File: rtl/req_arbiter.sv
// N-way arbiter with fixed or round-robin pick, grant held until release or timeout.
module req_arbiter
   import req_arbiter_pkg::*;
#(
   parameter int unsigned N        = DefN,
   parameter int unsigned IDX_W    = DefIdxW,
   parameter int unsigned MAX_HOLD = DefMaxHold,
   parameter int unsigned HOLD_W   = DefHoldW
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   input  logic             done,
   input  logic             fixed_pri,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             busy,
   output logic             timeout
);

   if (IDX_W != clog2(N)) begin : g_bad_idx_w
      $error("IDX_W must equal clog2(N)");
   end

   localparam bit               TimeoutEn = (MAX_HOLD != 0);
   localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

   arb_state_e        state_q, state_d;
   logic [N-1:0]      grant_q, grant_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [IDX_W-1:0]  last_q, last_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              timeout_q, timeout_d;

   logic [IDX_W-1:0]  winner;
   logic              any_req;
   logic              release_now;
   logic              expire;

   req_arbiter_pick #(
      .N     (N),
      .IDX_W (IDX_W)
   ) u_pick (
      .req       (req),
      .last      (last_q),
      .fixed_pri (fixed_pri),
      .winner    (winner),
      .any_req   (any_req)
   );

   assign release_now = done | ~req[idx_q];
   assign expire      = TimeoutEn && (hold_q == HoldLast);

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      idx_d     = idx_q;
      last_d    = last_q;
      hold_d    = hold_q;
      timeout_d = 1'b0;
      unique case (state_q)
         ArbIdle: begin
            if (any_req) begin
               state_d = ArbBusy;
               grant_d = N'(1) << winner;
               idx_d   = winner;
               last_d  = winner;
               hold_d  = '0;
            end
         end
         ArbBusy: begin
            // Release beats timeout when both land on the same cycle.
            if (release_now || expire) begin
               state_d   = ArbIdle;
               grant_d   = '0;
               idx_d     = '0;
               timeout_d = ~release_now;
            end else if (hold_q != '1) begin
               hold_d = hold_q + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ArbIdle;
         grant_q   <= '0;
         idx_q     <= '0;
         last_q    <= '0;
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         idx_q     <= idx_d;
         last_q    <= last_d;
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
      end
   end

   assign grant     = grant_q;
   assign grant_idx = idx_q;
   assign busy      = (state_q == ArbBusy);
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_req_arbiter.sv
// Randomized and directed bench for req_arbiter against a cycle-level reference model.
module tb_req_arbiter;

   localparam int unsigned N        = 4;
   localparam int unsigned IDX_W    = 2;
   localparam int unsigned MAX_HOLD = 15;
   localparam int unsigned HOLD_W   = 4;

   logic             clk;
   logic             rst_n;
   logic [N-1:0]     req;
   logic             done;
   logic             fixed_pri;
   logic [N-1:0]     grant;
   logic [IDX_W-1:0] grant_idx;
   logic             busy;
   logic             timeout;

   int n_vec;
   int n_err;

   // Reference model: owner (-1 when idle), cycles the grant has been visible, last owner.
   int m_owner;
   int m_held;
   int m_last;
   bit m_timeout;

   req_arbiter #(
      .N        (N),
      .IDX_W    (IDX_W),
      .MAX_HOLD (MAX_HOLD),
      .HOLD_W   (HOLD_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .done      (done),
      .fixed_pri (fixed_pri),
      .grant     (grant),
      .grant_idx (grant_idx),
      .busy      (busy),
      .timeout   (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pick(input logic [N-1:0] r, input int last, input bit fp);
      int start;
      int c;
      start = fp ? 0 : last;
      for (int k = 1; k <= N; k++) begin
         c = (start - k + N) % N;
         if (r[c]) return c;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner   = -1;
      m_held    = 0;
      m_last    = 0;
      m_timeout = 0;
   endtask

   task automatic model_edge(input logic [N-1:0] r, input logic d, input logic fp);
      int w;
      m_timeout = 0;
      if (m_owner < 0) begin
         w = pick(r, m_last, fp);
         if (w >= 0) begin
            m_owner = w;
            m_last  = w;
            m_held  = 1;
         end
      end else if (d || !r[m_owner]) begin
         m_owner = -1;
      end else if (MAX_HOLD != 0 && m_held >= MAX_HOLD) begin
         m_owner   = -1;
         m_timeout = 1;
      end else begin
         m_held++;
      end
   endtask

   // Called at a negedge; returns at the next negedge after checking all outputs.
   task automatic step(input logic [N-1:0] r, input logic d, input logic fp);
      logic [N-1:0] exp_grant;
      req       = r;
      done      = d;
      fixed_pri = fp;
      @(posedge clk);
      model_edge(r, d, fp);
      #1;
      exp_grant = (m_owner < 0) ? '0 : (N'(1) << m_owner);
      check_eq("grant", 32'(grant), 32'(exp_grant));
      check_eq("grant_idx", 32'(grant_idx), (m_owner < 0) ? 32'd0 : 32'(m_owner));
      check_eq("busy", 32'(busy), (m_owner < 0) ? 32'd0 : 32'd1);
      check_eq("timeout", 32'(timeout), 32'(m_timeout));
      @(negedge clk);
   endtask

   // Asynchronous reset asserted in the low phase, between edges.
   task automatic async_reset();
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("rst_grant", 32'(grant), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_idx", 32'(grant_idx), 32'd0);
      check_eq("rst_timeout", 32'(timeout), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int seq[$];
      int exp_seq[5];
      int cnt;
      bit prev_busy;
      logic [N-1:0] r;
      logic d;
      logic fp;

      n_vec = 0;
      n_err = 0;
      exp_seq = '{3, 2, 1, 0, 3};
      model_reset();

      // Reset held with all requests pending.
      rst_n = 1'b0; req = 4'b1111; done = 1'b0; fixed_pri = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         check_eq("t1_grant_in_reset", 32'(grant), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step(4'b1111, 1'b0, 1'b1);
      check_eq("t1_first_grant", 32'(grant), 32'b1000);
      check_eq("t1_first_idx", 32'(grant_idx), 32'd3);

      // Fixed priority starves index 1.
      async_reset();
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         step(4'b1010, m_owner >= 0, 1'b1);
         if (grant == 4'b0010) cnt++;
      end
      check_eq("t2_idx1_grants", 32'(cnt), 32'd0);

      // Round-robin rotation with all requesters active.
      async_reset();
      prev_busy = 1'b0;
      for (int i = 0; i < 40 && seq.size() < 5; i++) begin
         step(4'b1111, (m_owner >= 0) && (m_held >= 2), 1'b0);
         if (busy && !prev_busy) seq.push_back(int'(grant_idx));
         prev_busy = busy;
      end
      check_eq("t3_grants_seen", 32'(seq.size()), 32'd5);
      for (int i = 0; i < 5 && i < seq.size(); i++) begin
         check_eq($sformatf("t3_rr_idx%0d", i), 32'(seq[i]), 32'(exp_seq[i]));
      end

      // Round-robin from last=2.
      async_reset();
      step(4'b0100, 1'b0, 1'b1);
      step(4'b0100, 1'b1, 1'b1);
      step(4'b0101, 1'b0, 1'b0);
      check_eq("t4_idx_after_last2", 32'(grant_idx), 32'd0);
      step(4'b0101, 1'b1, 1'b0);
      step(4'b0101, 1'b0, 1'b0);
      check_eq("t4_idx_after_last0", 32'(grant_idx), 32'd2);

      // Timeout: grant visible exactly MAX_HOLD cycles then a one-cycle pulse.
      async_reset();
      step(4'b0001, 1'b0, 1'b1);
      cnt = grant[0] ? 1 : 0;
      for (int i = 0; i < 30; i++) begin
         step(4'b0001, 1'b0, 1'b1);
         if (grant == '0) break;
         cnt++;
      end
      check_eq("t5_hold_cycles", 32'(cnt), 32'(MAX_HOLD));
      check_eq("t5_timeout_pulse", 32'(timeout), 32'd1);
      step(4'b0001, 1'b0, 1'b1);
      check_eq("t5_timeout_cleared", 32'(timeout), 32'd0);
      for (int i = 0; i < 30 && m_held < MAX_HOLD; i++) step(4'b0001, 1'b0, 1'b1);
      step(4'b0001, 1'b1, 1'b1);
      check_eq("t5_done_beats_timeout", 32'(timeout), 32'd0);
      check_eq("t5_released", 32'(grant), 32'd0);

      // Owner drops its request, then reset mid-grant.
      async_reset();
      step(4'b0100, 1'b0, 1'b1);
      step(4'b0100, 1'b0, 1'b1);
      step(4'b0000, 1'b0, 1'b1);
      check_eq("t6_req_drop", 32'(grant), 32'd0);
      step(4'b0010, 1'b0, 1'b1);
      check_eq("t6_regrant", 32'(grant), 32'b0010);
      async_reset();

      // Randomized traffic with slowly varying requests.
      r  = 4'b0000;
      fp = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         for (int b = 0; b < N; b++) begin
            if ($urandom_range(7) == 0) r[b] = ~r[b];
         end
         if ($urandom_range(15) == 0) fp = ~fp;
         d = ($urandom_range(5) == 0);
         step(r, d, fp);
         if ($urandom_range(299) == 0) async_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
